ofmap_glb_writer: RTL

- Consumer end of the accumulator output interface. Takes quantized ofmap rows (ofmap_row/ofmap_valid, no backpressure) from the accumulation stage.
- Buffers the rows in a show-ahead FIFO and applies optional per-lane ReLU.
- Writes each row as one word into the global buffer (GLB) using a valid/ready write handshake and an auto-incrementing address.
- A start/done control FSM frames one tile of OFMAP_ROW_NUM rows.

---
 rtl/ofmap_glb_writer.sv | 106 ++++++++++
 1 files changed

// File: rtl/ofmap_glb_writer.sv
// Writes one tile of accumulator ofmap rows into the GLB, one row per word.
// A show-ahead row FIFO sits between the row strobe and the GLB write handshake. Optional ReLU is applied on entry.
module ofmap_glb_writer #(
    parameter int PE_SIZE       = 14,
    parameter int DATA_WIDTH    = 8,
    parameter int OFMAP_ROW_NUM = 70,
    parameter int BUF_DEPTH     = 8,
    parameter int ADDR_WIDTH    = 12,
    parameter int ADDR_STRIDE   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    input  logic                          relu_en_i,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] ofmap_row_i,
    input  logic                          ofmap_valid_i,
    output logic                          glb_wren_o,
    input  logic                          glb_ready_i,
    output logic [ADDR_WIDTH-1:0]         glb_addr_o,
    output logic [DATA_WIDTH*PE_SIZE-1:0] glb_wdata_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o
);
    localparam int ROW_W = DATA_WIDTH * PE_SIZE;
    localparam int CW    = $clog2(OFMAP_ROW_NUM + 1);
    localparam int PW    = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  relu_q;
    logic [CW-1:0]         in_cnt, wr_cnt, acc_cnt;
    logic [ROW_W-1:0]      mem [BUF_DEPTH];
    logic [PW:0]           wr_ptr, rd_ptr;
    logic [ROW_W-1:0]      relu_row;
    logic                  empty, full, pop, take, push, start_ok;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop      = !empty && glb_ready_i;
    assign take     = (state == RUN) && ofmap_valid_i;
    assign push     = take && (!full || pop);
    assign start_ok = (state == IDLE) && start_i;

    for (genvar k = 0; k < PE_SIZE; k++) begin : g_relu
        assign relu_row[DATA_WIDTH*k +: DATA_WIDTH] =
            (relu_q && ofmap_row_i[DATA_WIDTH*k + DATA_WIDTH-1]) ? '0 : ofmap_row_i[DATA_WIDTH*k +: DATA_WIDTH];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start_i) state_nx = RUN;
            RUN:   if (take && in_cnt == CW'(OFMAP_ROW_NUM - 1)) state_nx = DRAIN;
            DRAIN: if (wr_cnt == acc_cnt && empty) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_q     <= '0;
            relu_q     <= 1'b0;
            in_cnt     <= '0;
            wr_cnt     <= '0;
            acc_cnt    <= '0;
            overflow_o <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                base_q  <= base_addr_i;
                relu_q  <= relu_en_i;
                in_cnt  <= '0;
                wr_cnt  <= '0;
                acc_cnt <= '0;
            end else begin
                if (take) in_cnt  <= in_cnt + 1'b1;
                if (push) acc_cnt <= acc_cnt + 1'b1;
                if (pop)  wr_cnt  <= wr_cnt + 1'b1;
            end
            // A row dropped on the start cycle itself still counts as an overflow.
            if (ofmap_valid_i && !push) overflow_o <= 1'b1;
            else if (start_ok)          overflow_o <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= relu_row;
    end

    assign glb_wren_o  = !empty;
    assign glb_wdata_o = empty ? '0 : mem[rd_ptr[PW-1:0]];
    assign glb_addr_o  = base_q + ADDR_WIDTH'(wr_cnt) * ADDR_WIDTH'(ADDR_STRIDE);
    assign busy_o      = (state == RUN) || (state == DRAIN);
    assign done_o      = (state == DONE);
endmodule
